// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and the byte S-box used by the key schedule.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row-major FIPS-197 S-box; entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups, purely combinational.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_o[8*i +: 8] = sub_byte(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per accepted valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for start; last round key/index held
//   RUN   | round_key valid, advanced on each handshake until index 10 is taken
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  state_e     state_q, state_d;
  aes_block_t round_key_q, round_key_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic       done_q, done_d;

  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot_w, sub_w, t_w;
  aes_word_t  n0, n1, n2, n3;
  logic [7:0] rcon_sel;
  logic       handshake;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

  // rcon only matters below the last round; index 10 never expands.
  assign rcon_sel = (round_idx_q < NR) ? RCON[round_idx_q + 4'd1] : 8'h00;
  assign t_w      = sub_w ^ {rcon_sel, 24'h0};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;

  assign key_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign handshake = key_valid & key_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          round_key_d = key_in;
          round_idx_d = 4'd0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          if (round_idx_q == NR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            round_key_d = {n0, n1, n2, n3};
            round_idx_d = round_idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      done_q      <= done_d;
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign done      = done_q;

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion engine feeding round keys to the round datapath's `Key` input. On `start` it latches a 128-bit cipher key and presents round keys 0 through 10 one at a time. Each key is held on a valid/ready handshake and advanced on acceptance, so the downstream round controller consumes keys at its own pace. The engine computes one FIPS-197 key-expansion round per accepted handshake, on the fly, without storing the full schedule.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: load `key_in` and begin a schedule; sampled only in IDLE.
- `key_in` in 128: cipher key; bits [127:120] = byte 0, w0 = [127:96].
- `key_ready` in 1: downstream accepts the current round key.
- `round_key` out 128: current round key, same byte order as `key_in`.
- `round_idx` out 4: index 0..10 of `round_key`.
- `key_valid` out 1: `round_key` and `round_idx` are valid.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse after round key 10 is accepted.

## Operation
- States: IDLE, RUN.
- IDLE with `start`=1:
  - Register `round_key` ← `key_in` and `round_idx` ← 0.
  - Go to RUN.
- IDLE with `start`=0: hold.
- RUN behaviour:
  - `key_valid`=1 and `busy`=1 continuously.
  - Handshake occurs when `key_valid` & `key_ready`.
- Handshake in RUN with `round_idx`<10:
  - `round_key` ← expand(`round_key`, rcon[`round_idx`+1]).
  - `round_idx` ← `round_idx`+1.
- Handshake in RUN with `round_idx`=10:
  - Go to IDLE.
  - `done`=1 for the next cycle.
  - `round_key` and `round_idx` keep their last values; `key_valid`=0.
- No handshake in RUN: `round_key` and `round_idx` hold, so they are stable under backpressure.
- expand(k, rc), with w0..w3 taken from k [127:0]:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}, where RotWord maps bytes {a,b,c,d} to {b,c,d,a}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Combinational; registered on handshake.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. rcon[0] is unused.
- `start` during RUN is ignored; the schedule in progress is not restarted.
- `start` in the same cycle as `done`: accepted, because the FSM is in IDLE.

## Timing
- Reset values: state=IDLE, `round_key`=0, `round_idx`=0, `key_valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-schedule returns the block to these values immediately (asynchronous reset); no partial schedule resumes.
- Latency from `start` sampled high to `key_valid`=1 with `round_idx`=0 is 1 cycle.
- Latency from handshake to the next round key valid is 1 cycle.
- Full-rate throughput: one key per cycle when `key_ready` is held high, so 11 consecutive valid cycles.
- Minimum time from `start` to `done` is 12 cycles with `key_ready` held high.
- All outputs are registered. `key_valid` and `busy` decode from state; `done` is a flop.
- Combinational path: 4 S-box lookups plus XOR chain, single cycle.

## Structure
- Shared package `aes_pkg` holds:
  - `aes_word_t` (32-bit) and `aes_block_t` (128-bit).
  - `RCON` constant array (index 1..10).
  - `NR` = 10.
  - State enum {IDLE, RUN}.
- Sub-module `sub_word`: 32-bit in/out, four instances of the codebase S-box, purely combinational. Its lookups must match `subByte` byte-for-byte.
- Top level holds the FSM, key register, index counter and the expand XOR chain.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, `key_ready`=1:
  - Expect idx0 = input key.
  - Expect idx1 = a0fafe1788542cb123a339392a6c7605.
  - Expect idx2 = f2c295f27a96b9435935807a7359f67f.
  - Expect idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect `done` exactly 1 cycle after the idx10 handshake.
- All-zero key:
  - Expect idx1 = 62636363626363636263636362636363.
  - Expect idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: random `key_ready` on the A.1 key.
  - Expect the same 11 keys, in order, with no skipped or repeated index.
  - Expect `round_key` stable while `key_ready`=0.
- `start` pulsed during RUN with a different key: ignored; the A.1 sequence completes unchanged.
- `rst_n` dropped at idx 5: all outputs return to 0 immediately. A new `start` after release yields idx0 = the new key.
- `start` held high across `done`: a second schedule begins; idx0 valid 1 cycle after the `done` cycle.
